// File: rtl/carram_packer.sv
// carram_packer
// Writer side of the car sprite RAM. Accepts a raster-order stream of 5-bit
// palette indices and packs four pixels into each 20-bit RAM word so the
// sprite fetch path can read them back unchanged.
//   pixel p = x + y*SPRITE_W, word = p >> 2, slot = p[1:0]
//   slot 0 -> [19:15], slot 1 -> [14:10], slot 2 -> [9:5], slot 3 -> [4:0]
//
// Ports:
//   clk        system clock
//   reset_n    asynchronous active-low reset
//   start      one-cycle pulse, begins a load when idle
//   in_valid   pixel_idx carries a pixel
//   in_ready   packer accepts a pixel this cycle
//   pixel_idx  palette index of the next raster pixel
//   wr_en      RAM write strobe (one cycle per word)
//   wr_addr    RAM word address
//   wr_data    packed word
//   busy       high while loading and in the final done cycle
//   done       one-cycle pulse alongside the last word's write
module carram_packer #(
  parameter int         SPRITE_W = 404,
  parameter int         SPRITE_H = 160,
  parameter logic [4:0] PAD_IDX  = 5'd0
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [4:0]  pixel_idx,
  output logic        wr_en,
  output logic [13:0] wr_addr,
  output logic [19:0] wr_data,
  output logic        busy,
  output logic        done
);

  localparam int          TOTAL    = SPRITE_W * SPRITE_H;
  localparam logic [15:0] LAST_PIX = 16'(TOTAL - 1);
  localparam logic [19:0] PAD_WORD = {4{PAD_IDX}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state;
  state_t      state_next;
  logic [15:0] pcnt;
  logic [19:0] asm_word;
  logic [19:0] asm_next;
  logic        xfer;
  logic        last_pix;
  logic        commit;

  assign xfer     = in_valid && in_ready;
  assign last_pix = (pcnt == LAST_PIX);
  // A word is closed either when its fourth slot fills or when the stream
  // ends early inside it; in the latter case the untouched slots still hold
  // the padding loaded at word start.
  assign commit   = xfer && ((pcnt[1:0] == 2'd3) || last_pix);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_next = LOAD;
        end
      end
      LOAD: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        if (xfer && last_pix) begin
          state_next = DONE;
        end
      end
      DONE: begin
        busy       = 1'b1;
        done       = 1'b1;
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Drop the incoming pixel into its slot of the word being assembled.
  always_comb begin
    asm_next = asm_word;
    case (pcnt[1:0])
      2'd0:    asm_next[19:15] = pixel_idx;
      2'd1:    asm_next[14:10] = pixel_idx;
      2'd2:    asm_next[9:5]   = pixel_idx;
      default: asm_next[4:0]   = pixel_idx;
    endcase
  end

  // Datapath. The write is launched from the committing transfer's edge, so
  // the RAM sees it exactly one cycle later, and the assembly register is
  // refilled with padding at the same edge so no slot leaks into the next word.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pcnt     <= 16'd0;
      asm_word <= 20'd0;
      wr_en    <= 1'b0;
      wr_addr  <= 14'd0;
      wr_data  <= 20'd0;
    end else begin
      wr_en <= 1'b0;
      if ((state == IDLE) && start) begin
        pcnt     <= 16'd0;
        asm_word <= PAD_WORD;
      end else if (xfer) begin
        pcnt <= pcnt + 16'd1;
        if (commit) begin
          wr_en    <= 1'b1;
          wr_addr  <= pcnt[15:2];
          wr_data  <= asm_next;
          asm_word <= PAD_WORD;
        end else begin
          asm_word <= asm_next;
        end
      end
    end
  end

endmodule

// File: tb/tb_carram_packer.sv
// tb_carram_packer
// Directed bench for carram_packer. Four instances share the pixel bus:
//   a: 5x2, PAD 0      b: 5x2, PAD 31 (driven together with a)
//   c: 4x2, PAD 0      d: default 404x160, checked by full read-back
// Expected writes are queued when a load is launched and popped by per-
// instance monitors whenever the DUT strobes wr_en.
module tb_carram_packer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;

  logic       rst_ab_n, rst_n;
  logic       start_ab, start_c, start_d;
  logic       in_valid;
  logic [4:0] pixel_idx;

  logic        a_in_ready, a_wr_en, a_busy, a_done;
  logic [13:0] a_wr_addr;
  logic [19:0] a_wr_data;
  logic        b_in_ready, b_wr_en, b_busy, b_done;
  logic [13:0] b_wr_addr;
  logic [19:0] b_wr_data;
  logic        c_in_ready, c_wr_en, c_busy, c_done;
  logic [13:0] c_wr_addr;
  logic [19:0] c_wr_data;
  logic        d_in_ready, d_wr_en, d_busy, d_done;
  logic [13:0] d_wr_addr;
  logic [19:0] d_wr_data;

  // Scoreboard entries are {done, addr, data}.
  logic [34:0] exp_a[$];
  logic [34:0] exp_b[$];
  logic [34:0] exp_c[$];

  localparam int D_W     = 404;
  localparam int D_H     = 160;
  localparam int D_TOTAL = D_W * D_H;

  logic [19:0] ram_d [0:16383];
  logic [4:0]  src_d [0:D_TOTAL-1];
  int          d_writes    = 0;
  logic [13:0] d_last_addr = 14'h3FFF;

  carram_packer #(.SPRITE_W(5), .SPRITE_H(2), .PAD_IDX(5'd0)) u_a (
    .clk(clk), .reset_n(rst_ab_n), .start(start_ab), .in_valid(in_valid),
    .in_ready(a_in_ready), .pixel_idx(pixel_idx), .wr_en(a_wr_en),
    .wr_addr(a_wr_addr), .wr_data(a_wr_data), .busy(a_busy), .done(a_done)
  );

  carram_packer #(.SPRITE_W(5), .SPRITE_H(2), .PAD_IDX(5'd31)) u_b (
    .clk(clk), .reset_n(rst_ab_n), .start(start_ab), .in_valid(in_valid),
    .in_ready(b_in_ready), .pixel_idx(pixel_idx), .wr_en(b_wr_en),
    .wr_addr(b_wr_addr), .wr_data(b_wr_data), .busy(b_busy), .done(b_done)
  );

  carram_packer #(.SPRITE_W(4), .SPRITE_H(2), .PAD_IDX(5'd0)) u_c (
    .clk(clk), .reset_n(rst_n), .start(start_c), .in_valid(in_valid),
    .in_ready(c_in_ready), .pixel_idx(pixel_idx), .wr_en(c_wr_en),
    .wr_addr(c_wr_addr), .wr_data(c_wr_data), .busy(c_busy), .done(c_done)
  );

  carram_packer u_d (
    .clk(clk), .reset_n(rst_n), .start(start_d), .in_valid(in_valid),
    .in_ready(d_in_ready), .pixel_idx(pixel_idx), .wr_en(d_wr_en),
    .wr_addr(d_wr_addr), .wr_data(d_wr_data), .busy(d_busy), .done(d_done)
  );

  task automatic check_output(input string tag, input logic [63:0] observed,
                              input logic [63:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  // One pixel presented for exactly one clock; inputs change 1 time unit
  // after the rising edge so the DUT never sees them move at its edge.
  task automatic apply_stimulus(input logic [4:0] v);
    in_valid  = 1'b1;
    pixel_idx = v;
    @(posedge clk); #1;
    in_valid  = 1'b0;
  endtask

  task automatic pulse_start_ab();
    start_ab = 1'b1;
    @(posedge clk); #1;
    start_ab = 1'b0;
  endtask

  task automatic push_ab_full();
    exp_a.push_back({1'b0, 14'd0, 20'h08864});
    exp_a.push_back({1'b0, 14'd1, 20'h298E8});
    exp_a.push_back({1'b1, 14'd2, 20'h4A800});
    exp_b.push_back({1'b0, 14'd0, 20'h08864});
    exp_b.push_back({1'b0, 14'd1, 20'h298E8});
    exp_b.push_back({1'b1, 14'd2, 20'h4ABFF});
  endtask

  task automatic finish_ab(input string tag);
    in_valid = 1'b0;
    @(posedge clk); #1;
    check_output({tag, "_idle_after_done"}, {a_busy, b_busy, a_done, b_done}, 4'b0000);
    check_output({tag, "_a_writes_left"}, exp_a.size(), 0);
    check_output({tag, "_b_writes_left"}, exp_b.size(), 0);
  endtask

  // Monitors sample on the falling edge, half a cycle away from the DUT's
  // active edge. A write with nothing queued is always a failure, which also
  // catches writes during input gaps or after a discarded partial word.
  always @(negedge clk) begin
    if (a_wr_en) begin
      if (exp_a.size() == 0) check_output("a_spurious_write", a_wr_en, 1'b0);
      else check_output("a_write", {a_done, a_wr_addr, a_wr_data}, exp_a.pop_front());
    end else if (a_done) begin
      check_output("a_done_without_write", a_done, 1'b0);
    end
  end

  always @(negedge clk) begin
    if (b_wr_en) begin
      if (exp_b.size() == 0) check_output("b_spurious_write", b_wr_en, 1'b0);
      else check_output("b_write", {b_done, b_wr_addr, b_wr_data}, exp_b.pop_front());
    end else if (b_done) begin
      check_output("b_done_without_write", b_done, 1'b0);
    end
  end

  always @(negedge clk) begin
    if (c_wr_en) begin
      if (exp_c.size() == 0) check_output("c_spurious_write", c_wr_en, 1'b0);
      else check_output("c_write", {c_done, c_wr_addr, c_wr_data}, exp_c.pop_front());
    end else if (c_done) begin
      check_output("c_done_without_write", c_done, 1'b0);
    end
  end

  // Instance d feeds a behavioural model of car_ram; the fetch path is then
  // emulated by reading that model back.
  always @(negedge clk) begin
    if (d_wr_en) begin
      ram_d[d_wr_addr] = d_wr_data;
      d_writes++;
      if (d_done) d_last_addr = d_wr_addr;
    end else if (d_done) begin
      check_output("d_done_without_write", d_done, 1'b0);
    end
  end

  initial begin
    rst_ab_n  = 1'b0;
    rst_n     = 1'b0;
    start_ab  = 1'b0;
    start_c   = 1'b0;
    start_d   = 1'b0;
    in_valid  = 1'b0;
    pixel_idx = 5'd0;
    repeat (2) @(posedge clk);
    #1;

    // Every output is zero while reset is held.
    check_output("a_reset_outputs", {a_in_ready, a_wr_en, a_wr_addr, a_wr_data, a_busy, a_done}, 0);
    check_output("b_reset_outputs", {b_in_ready, b_wr_en, b_wr_addr, b_wr_data, b_busy, b_done}, 0);
    check_output("c_reset_outputs", {c_in_ready, c_wr_en, c_wr_addr, c_wr_data, c_busy, c_done}, 0);
    check_output("d_reset_outputs", {d_in_ready, d_wr_en, d_wr_addr, d_wr_data, d_busy, d_done}, 0);
    rst_ab_n = 1'b1;
    rst_n    = 1'b1;
    @(posedge clk); #1;

    // 5x2 back-to-back stream, pads 0 and 31.
    push_ab_full();
    pulse_start_ab();
    check_output("ab_load_flags", {a_in_ready, a_busy, b_in_ready, b_busy}, 4'b1111);
    for (int i = 1; i <= 10; i++) apply_stimulus(5'(i));
    finish_ab("stream1");

    // start re-pulsed mid-load must not restart the count.
    push_ab_full();
    pulse_start_ab();
    for (int i = 1; i <= 3; i++) apply_stimulus(5'(i));
    start_ab = 1'b1;
    apply_stimulus(5'd4);
    start_ab = 1'b0;
    for (int i = 5; i <= 10; i++) apply_stimulus(5'(i));
    finish_ab("restart_ignored");

    // Reset after 6 pixels: only word 0 may ever appear.
    exp_a.push_back({1'b0, 14'd0, 20'h08864});
    exp_b.push_back({1'b0, 14'd0, 20'h08864});
    pulse_start_ab();
    for (int i = 1; i <= 6; i++) apply_stimulus(5'(i));
    rst_ab_n = 1'b0;
    #1;
    check_output("a_midload_reset_outputs", {a_in_ready, a_wr_en, a_wr_addr, a_wr_data, a_busy, a_done}, 0);
    check_output("b_midload_reset_outputs", {b_in_ready, b_wr_en, b_wr_addr, b_wr_data, b_busy, b_done}, 0);
    @(posedge clk); #1;
    rst_ab_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_output("a_after_reset_writes_left", exp_a.size(), 0);
    check_output("a_after_reset_idle", {a_busy, a_in_ready, a_wr_en}, 3'b000);

    // Fresh load after the reset reproduces the first stream.
    push_ab_full();
    pulse_start_ab();
    for (int i = 1; i <= 10; i++) apply_stimulus(5'(i));
    finish_ab("after_reset");

    // 4x2 with in_valid toggling; the idle cycles carry a decoy index.
    begin
      logic [4:0] pix_c [0:7];
      pix_c = '{5'd31, 5'd0, 5'd31, 5'd0, 5'd1, 5'd2, 5'd3, 5'd4};
      exp_c.push_back({1'b0, 14'd0, 20'hF83E0});
      exp_c.push_back({1'b1, 14'd1, 20'h08864});
      start_c = 1'b1;
      @(posedge clk); #1;
      start_c = 1'b0;
      for (int i = 0; i < 8; i++) begin
        apply_stimulus(pix_c[i]);
        pixel_idx = 5'h15;
        @(posedge clk); #1;
      end
      check_output("c_writes_left", exp_c.size(), 0);
      check_output("c_idle_after_done", {c_busy, c_done}, 2'b00);
    end

    // Full-size 404x160 load of random indices, then read back per (x,y).
    start_d = 1'b1;
    @(posedge clk); #1;
    start_d = 1'b0;
    for (int p = 0; p < D_TOTAL; p++) begin
      src_d[p] = 5'($urandom_range(0, 31));
      apply_stimulus(src_d[p]);
    end
    repeat (2) @(posedge clk);
    #1;
    check_output("d_word_count", d_writes, (D_TOTAL + 3) / 4);
    check_output("d_last_word_addr", d_last_addr, 14'd16159);
    check_output("d_idle_after_done", {d_busy, d_in_ready}, 2'b00);
    for (int y = 0; y < D_H; y++) begin
      for (int x = 0; x < D_W; x++) begin
        int          p;
        int          s;
        logic [19:0] w;
        p = x + y * D_W;
        s = p % 4;
        w = ram_d[p >> 2];
        check_output($sformatf("d_readback_x%0d_y%0d", x, y), w[19 - 5 * s -: 5], src_d[p]);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/carram_packer.md
Name: carram_packer

Overview:
- Writer side of the car sprite RAM. It accepts a raster-order stream of 5-bit palette indices and packs four pixels into each 20-bit RAM word.
- It drives the RAM write port so the sprite fetch path reads back the same indices.
- Packing contract: pixel index p = x + y*SPRITE_W; word address = p >> 2; slot = p[1:0].
- Slot 0 maps to bits [19:15], slot 1 to [14:10], slot 2 to [9:5], slot 3 to [4:0].
- Sits between the sprite loader (SD/JTAG/ROM source) and car_ram port A.

Parameters:
- SPRITE_W, 404, sprite width in pixels.
- SPRITE_H, 160, sprite height in pixels; SPRITE_W*SPRITE_H must not exceed 65536.
- PAD_IDX, 5'd0, fill value for unused slots of a final partial word.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse; begins a load when IDLE.
- in_valid  in  1  pixel_idx is valid.
- in_ready  out  1  packer accepts a pixel this cycle.
- pixel_idx  in  5  palette index of the next raster pixel.
- wr_en  out  1  RAM write strobe.
- wr_addr  out  14  RAM word address.
- wr_data  out  20  packed word.
- busy  out  1  high in LOAD and DONE.
- done  out  1  one-cycle pulse when the final word has been written.

Behaviour:
- Reset is asynchronous and active-low: clk is the only clock; reset_n asserted low forces state IDLE. All outputs go to 0; the pixel counter, slot shift register and word address also clear.
- States:
  - IDLE: in_ready=0. start=1 clears counters and moves to LOAD.
  - LOAD: in_ready=1. Transfer occurs when in_valid&&in_ready.
  - DONE: done=1 for exactly one cycle, then IDLE.
- start outside IDLE is ignored.
- Pixel counter pcnt is 16 bits and counts accepted pixels. TOTAL = SPRITE_W*SPRITE_H. slot = pcnt[1:0], word = pcnt[15:2].
- On each transfer, pixel_idx is written into slot position slot of a 20-bit assembly register.
- A word commits on a transfer where slot==3 or pcnt==TOTAL-1:
  - Next cycle: wr_en=1 for one cycle, wr_addr=word, wr_data=assembled word.
  - On a partial final word, slots above the last filled slot hold PAD_IDX.
- Write latency is exactly 1 cycle after the committing transfer. There is no backpressure from the RAM, and in_ready stays high during a write cycle, so a new pixel may be accepted in the same cycle its predecessor word is written.
- After the final transfer (pcnt==TOTAL-1): state goes to DONE in the same edge as the final write's launch. done asserts in the cycle wr_en shows the last word. The total word count written is ceil(TOTAL/4).
- A gap in in_valid holds all state; there is no timeout.
- Slots must not leak between words: the assembly register is reset to all-PAD_IDX at each word start.
- wr_addr is 14-bit. Address wrap cannot occur given the SPRITE_W*SPRITE_H limit; exceeding it is a configuration error and is not handled.
- If reset_n is asserted mid-load, any partial word is discarded and no write is issued.

Test Plan:
- SPRITE_W=5, SPRITE_H=2, PAD_IDX=0: start, then pixels 1..10 streamed back-to-back. Required writes:
  - addr0 = 0x08864
  - addr1 = 0x298E8
  - addr2 = 0x4A800 (partial word)
  - done coincides with the addr2 write; busy then drops.
- Same configuration with PAD_IDX=5'd31: the final word must be 0x4A800|0x003FF = 0x4ABFF.
- SPRITE_W=4, SPRITE_H=2: pixels 31,0,31,0,1,2,3,4 with in_valid toggling every other cycle. Required: exactly 2 writes, addr0=0xF83E0 and addr1=0x08864, with no writes during gaps.
- start pulsed again while in LOAD: no counter reset, no extra writes, and the stream completes normally.
- reset_n driven low after 6 of 10 pixels (5x2 config):
  - All outputs go to 0 immediately; addr1 is never written.
  - A fresh start and 10 pixels reproduce the addr0/addr1/addr2 sequence of the first scenario.
- Read-back check, default 404x160: stream pseudo-random indices, then read car_ram through the fetch path over all (x,y). Every colorIdx must match its source, including the last pixel (x=403, y=159), word 16159, slot 3.
